// File: rtl/div_iter.sv
// rtl/div_iter.sv - multi-cycle radix-2 restoring divider (DIV/DIVU) for the EX stage
module div_iter #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    // Iteration counter must be able to hold DATA_W itself (the "done" value).
    localparam int                CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        FREE      = 2'b00,
        DIVBYZERO = 2'b01,
        DIVON     = 2'b10,
        DIVEND    = 2'b11
    } state_t;

    state_t state;
    state_t state_nx;

    // Working registers. shift_q starts as |dividend|; each iteration shifts
    // its MSB into the partial remainder and a quotient bit into its LSB, so
    // after DATA_W iterations it holds the unsigned quotient.
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic [DATA_W-1:0]  shift_q;
    logic [DATA_W-1:0]  shift_nx;
    logic [DATA_W-1:0]  divisor_q;
    logic [DATA_W-1:0]  divisor_nx;
    logic [DATA_W-1:0]  rem_q;
    logic [DATA_W-1:0]  rem_nx;
    logic               sign_q;
    logic               sign_q_nx;
    logic               sign_r;
    logic               sign_r_nx;
    logic [2*DATA_W-1:0] result_nx;
    logic               ready_nx;

    // Request withdrawn or flushed; honoured everywhere except DIVEND.
    logic               abort;
    logic               div_zero;
    logic [DATA_W-1:0]  opa_abs;
    logic [DATA_W-1:0]  opb_abs;

    // One restoring step: 33-bit compare, 32-bit subtract is enough because
    // the partial remainder is always below the divisor afterwards.
    logic [DATA_W:0]    minuend;
    logic [DATA_W-1:0]  diff;
    logic               take;
    logic [DATA_W-1:0]  quo_fix;
    logic [DATA_W-1:0]  rem_fix;

    assign abort    = (~start_i) | annul_i;
    assign div_zero = (opdata2_i == '0);
    assign opa_abs  = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    assign opb_abs  = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

    assign minuend  = {rem_q, shift_q[DATA_W-1]};
    assign take     = (minuend >= {1'b0, divisor_q});
    assign diff     = minuend[DATA_W-1:0] - divisor_q;

    // Final sign correction of the magnitudes produced by the iterations.
    assign quo_fix  = sign_q ? (~shift_q + 1'b1) : shift_q;
    assign rem_fix  = sign_r ? (~rem_q + 1'b1) : rem_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FREE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            FREE: begin
                if (!abort) begin
                    state_nx = div_zero ? DIVBYZERO : DIVON;
                end
            end
            DIVBYZERO: begin
                state_nx = abort ? FREE : DIVEND;
            end
            DIVON: begin
                if (abort) begin
                    state_nx = FREE;
                end else if (cnt == CNT_LAST) begin
                    state_nx = DIVEND;
                end
            end
            DIVEND: begin
                if (!start_i) begin
                    state_nx = FREE;
                end
            end
            default: state_nx = FREE;
        endcase
    end

    // Datapath next values: operand capture in FREE, one shift/subtract per DIVON cycle.
    always_comb begin
        cnt_nx     = cnt;
        shift_nx   = shift_q;
        divisor_nx = divisor_q;
        rem_nx     = rem_q;
        sign_q_nx  = sign_q;
        sign_r_nx  = sign_r;
        case (state)
            FREE: begin
                if (!abort && !div_zero) begin
                    cnt_nx     = '0;
                    shift_nx   = opa_abs;
                    divisor_nx = opb_abs;
                    rem_nx     = '0;
                    sign_q_nx  = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                    sign_r_nx  = signed_div_i & opdata1_i[DATA_W-1];
                end
            end
            DIVON: begin
                if (abort || (cnt == CNT_LAST)) begin
                    cnt_nx = '0;
                end else begin
                    rem_nx   = take ? diff : minuend[DATA_W-1:0];
                    shift_nx = {shift_q[DATA_W-2:0], take};
                    cnt_nx   = cnt + CNT_ONE;
                end
            end
            default: begin
                cnt_nx = '0;
            end
        endcase
    end

    // Output next values; result and ready change only on state transitions.
    always_comb begin
        result_nx = result_o;
        ready_nx  = ready_o;
        case (state)
            FREE: begin
                result_nx = '0;
                ready_nx  = 1'b0;
            end
            DIVBYZERO: begin
                // Architecturally undefined; a fixed zero keeps HI/LO deterministic.
                result_nx = '0;
                ready_nx  = ~abort;
            end
            DIVON: begin
                if (abort) begin
                    result_nx = '0;
                    ready_nx  = 1'b0;
                end else if (cnt == CNT_LAST) begin
                    result_nx = {rem_fix, quo_fix};
                    ready_nx  = 1'b1;
                end else begin
                    result_nx = '0;
                    ready_nx  = 1'b0;
                end
            end
            DIVEND: begin
                // The result is complete, so a flush here is ignored until start drops.
                if (!start_i) begin
                    result_nx = '0;
                    ready_nx  = 1'b0;
                end
            end
            default: begin
                result_nx = '0;
                ready_nx  = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            shift_q   <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            result_o  <= '0;
            ready_o   <= 1'b0;
        end else begin
            cnt       <= cnt_nx;
            shift_q   <= shift_nx;
            divisor_q <= divisor_nx;
            rem_q     <= rem_nx;
            sign_q    <= sign_q_nx;
            sign_r    <= sign_r_nx;
            result_o  <= result_nx;
            ready_o   <= ready_nx;
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - directed and random checks of div_iter against a scoreboard
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int n_vec;
    int n_err;
    logic [63:0] sb_q[$];

    div_iter #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opa),
        .opdata2_i    (opb),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result using 64-bit arithmetic, avoiding 32-bit overflow on MIN/-1.
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint da;
        longint db;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            da = longint'($signed(a));
            db = longint'($signed(b));
        end else begin
            da = longint'({32'd0, a});
            db = longint'({32'd0, b});
        end
        q = da / db;
        r = da % db;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic pop_check(input string tag);
        logic [63:0] exp;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            exp = sb_q.pop_front();
            check(tag, result, exp);
        end
    endtask

    // Full transaction: drive, wait for ready with a bound, compare, hold, release.
    task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp,
                           input int exp_lat, input bit perturb);
        int n;
        logic [63:0] held;
        signed_div = s;
        opa        = a;
        opb        = b;
        start      = 1'b1;
        sb_q.push_back(exp);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (perturb && n == 1) begin
                opa        = $urandom;
                opb        = $urandom;
                signed_div = ~s;
            end
        end while (!ready && n < 200);
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        held = result;
        pop_check({tag, "_result"});
        annul = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_hold_ready"}, 64'(ready), 64'd1);
        check({tag, "_hold_result"}, result, held);
        annul = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_drop_ready"}, 64'(ready), 64'd0);
        check({tag, "_drop_result"}, result, 64'd0);
    endtask

    initial begin
        int n;
        bit seen;
        logic        rs;
        logic [31:0] ra;
        logic [31:0] rb;

        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        opa        = 32'd0;
        opb        = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_result", result, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, 1'b0);
        run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34, 1'b0);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34, 1'b0);
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 64'd0, 2, 1'b0);
        run_div("div_m5_0", 1'b1, 32'hFFFFFFFB, 32'd0, 64'd0, 2, 1'b0);
        run_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34, 1'b0);
        run_div("divu_min_m1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 34, 1'b0);
        run_div("div_0_9", 1'b1, 32'd0, 32'd9, 64'd0, 34, 1'b0);

        // Flush partway through the iterations.
        signed_div = 1'b0;
        opa        = 32'hFFFFFFFF;
        opb        = 32'd3;
        start      = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        annul = 1'b1;
        @(posedge clk);
        #1;
        check("annul_ready", 64'(ready), 64'd0);
        check("annul_result", result, 64'd0);
        annul = 1'b0;
        start = 1'b0;
        seen  = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready) seen = 1'b1;
        end
        check("annul_never_ready", 64'(seen), 64'd0);
        run_div("restart_9_4", 1'b0, 32'd9, 32'd4, 64'h00000001_00000002, 34, 1'b0);

        // Start and annul together in FREE must not launch a division.
        opa   = 32'd100;
        opb   = 32'd7;
        start = 1'b1;
        annul = 1'b1;
        seen  = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (ready) seen = 1'b1;
        end
        check("start_annul_free", 64'(seen), 64'd0);
        annul = 1'b0;
        run_div("after_annul_free", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, 1'b0);

        // Operands and mode changed right after sampling.
        run_div("perturb", 1'b1, 32'hFFFFFF9C, 32'd7, model(1'b1, 32'hFFFFFF9C, 32'd7), 34, 1'b1);

        // Asynchronous reset while iterating.
        signed_div = 1'b0;
        opa        = 32'd1000;
        opb        = 32'd3;
        start      = 1'b1;
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_divon_ready", 64'(ready), 64'd0);
        check("rst_divon_result", result, 64'd0);
        start = 1'b0;
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset while holding a finished result.
        signed_div = 1'b0;
        opa        = 32'd1000;
        opb        = 32'd3;
        start      = 1'b1;
        sb_q.push_back(64'h00000001_0000014D);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready && n < 200);
        check("rst_divend_latency", 64'(n), 64'd34);
        pop_check("rst_divend_result_pre");
        #2;
        rst = 1'b1;
        #1;
        check("rst_divend_ready", 64'(ready), 64'd0);
        check("rst_divend_result", result, 64'd0);
        start = 1'b0;
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Random operands with a few forced corner shapes.
        for (int i = 0; i < 8; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            if (i == 0) rb = 32'($urandom_range(1, 15));
            if (i == 1) ra = 32'd0;
            if (i == 2) rb = 32'd1;
            if (i == 3) rb = 32'hFFFFFFFF;
            if (i == 4) rb = {16'd0, rb[15:0]} | 32'd1;
            run_div("random", rs, ra, rb, model(rs, ra, rb), (rb == 32'd0) ? 2 : 34, 1'b0);
        end

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
